// File: rtl/ddr2_cmd_decoder.sv
// ddr2_cmd_decoder
//   Decodes the rank-0 DDR2 command/address bus, tracks per-bank row state
//   and the ACT/PRE/REF timing windows, and flags illegal, out-of-state and
//   too-early commands. Every output is registered: one cycle of latency.
//
// Ports
//   clk_i, rst_n_i        command clock, async active-low reset
//   cke_i, cs_n_i[1:0]    clock enable, chip selects (only cs_n_i[0] decoded)
//   ras_n_i/cas_n_i/we_n_i command strobes
//   ba_i[1:0], addr_i[14:0] bank / row-col-MR address
//   cmd_valid_o, cmd_code_o[2:0]  decoded command pulse and code
//                                 (0 NOP 1 ACT 2 RD 3 WR 4 PRE 5 PREA 6 REF 7 MRS)
//   cmd_ba_o, cmd_row_o, cmd_col_o, cmd_ap_o  decoded fields
//   bank_open_o[3:0]      bank i currently ACTIVE
//   err_state_o, err_timing_o, err_illegal_o  one-cycle error pulses
//   err_cnt_o[7:0]        saturating errored-command count
//
// Timing counters are loaded with T-1 at the command edge: the command edge
// itself is the first of the T cycles, so a follow-up command exactly T edges
// later sees the counter at 0 and is legal.

// Per-bank state machine with a shared tRCD/tRAS countdown and a tRP countdown.
// act_i / pre_i are only asserted by the parent for commands already judged legal.
module ddr2_bank #(
  parameter int unsigned T_RCD = 4,
  parameter int unsigned T_RP  = 4,
  parameter int unsigned T_RAS = 12
) (
  input  logic gclk_unused_i,
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic act_i,
  input  logic pre_i,
  output logic active_o,
  output logic rp_zero_o,
  output logic rcd_ok_o,
  output logic ras_ok_o
);
  // One down-counter covers both windows: it starts at the longer of the two
  // and each window has expired once the counter falls to its threshold.
  localparam int unsigned RC_MAX  = (T_RCD > T_RAS) ? T_RCD : T_RAS;
  localparam logic [7:0]  RC_LOAD = 8'(RC_MAX - 1);
  localparam logic [7:0]  RCD_THR = 8'(RC_MAX - T_RCD);
  localparam logic [7:0]  RAS_THR = 8'(RC_MAX - T_RAS);
  localparam logic [7:0]  RP_LOAD = 8'(T_RP - 1);

  typedef enum logic [1:0] {B_IDLE = 2'd0, B_ACTIVE = 2'd1, B_PRECHG = 2'd2} bank_st_e;

  bank_st_e   state_q, state_d;
  logic [7:0] rc_q, rc_d, rp_q, rp_d;

  always_comb begin
    state_d = state_q;
    rc_d    = (rc_q != 8'd0) ? rc_q - 8'd1 : 8'd0;
    rp_d    = (rp_q != 8'd0) ? rp_q - 8'd1 : 8'd0;
    if (state_q == B_PRECHG && rp_q == 8'd0) state_d = B_IDLE;
    if (act_i) begin
      state_d = B_ACTIVE;
      rc_d    = RC_LOAD;
    end else if (pre_i) begin
      state_d = B_PRECHG;
      rp_d    = RP_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= B_IDLE;
      rc_q    <= 8'd0;
      rp_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rp_q    <= rp_d;
    end
  end

  assign active_o  = (state_q == B_ACTIVE);
  assign rp_zero_o = (rp_q == 8'd0);
  assign rcd_ok_o  = (rc_q <= RCD_THR);
  assign ras_ok_o  = (rc_q <= RAS_THR);

  logic unused_ok;
  assign unused_ok = gclk_unused_i;
endmodule

module ddr2_cmd_decoder #(
  parameter int unsigned T_RCD = 4,
  parameter int unsigned T_RP  = 4,
  parameter int unsigned T_RAS = 12,
  parameter int unsigned T_RFC = 43
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cke_i,
  input  logic [1:0]  cs_n_i,
  input  logic        ras_n_i,
  input  logic        cas_n_i,
  input  logic        we_n_i,
  input  logic [1:0]  ba_i,
  input  logic [14:0] addr_i,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_code_o,
  output logic [1:0]  cmd_ba_o,
  output logic [14:0] cmd_row_o,
  output logic [9:0]  cmd_col_o,
  output logic        cmd_ap_o,
  output logic [3:0]  bank_open_o,
  output logic        err_state_o,
  output logic        err_timing_o,
  output logic        err_illegal_o,
  output logic [7:0]  err_cnt_o
);
  localparam int unsigned NUM_BANKS = 4;
  localparam logic [7:0]  RFC_LOAD  = 8'(T_RFC - 1);

  // {ras_n,cas_n,we_n} encodings
  localparam logic [2:0] E_MRS = 3'b000, E_REF = 3'b001, E_PRE = 3'b010, E_ACT = 3'b011;
  localparam logic [2:0] E_WR  = 3'b100, E_RD  = 3'b101, E_ILL = 3'b110, E_NOP = 3'b111;
  // output command codes
  localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5, C_REF = 3'd6, C_MRS = 3'd7;

  typedef struct packed {
    logic        valid;
    logic [2:0]  code;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [9:0]  col;
    logic        ap;
    logic        es;
    logic        et;
    logic        ei;
  } rsp_t;

  rsp_t                 rsp_q, rsp_d;
  logic [7:0]           cnt_q, cnt_d, rfc_q, rfc_d;
  logic [2:0]           rcw;
  logic                 is_cmd, st_err, tm_err, ill, err_any, ref_want;
  logic [NUM_BANKS-1:0] bsel, act_want, pre_want, act_go, pre_go;
  logic [NUM_BANKS-1:0] act_v, rp_zero_v, rcd_ok_v, ras_ok_v;

  assign rcw    = {ras_n_i, cas_n_i, we_n_i};
  assign is_cmd = cke_i & ~cs_n_i[0] & (rcw != E_NOP);
  assign bsel   = NUM_BANKS'(1) << ba_i;

  always_comb begin
    rsp_d    = '0;
    st_err   = 1'b0;
    tm_err   = 1'b0;
    ill      = 1'b0;
    act_want = '0;
    pre_want = '0;
    ref_want = 1'b0;
    if (is_cmd) begin
      rsp_d.valid = 1'b1;
      rsp_d.ba    = ba_i;
      case (rcw)
        E_ACT: begin
          rsp_d.code = C_ACT;
          rsp_d.row  = addr_i;
          act_want   = bsel;
          // A bank still precharging is a timing problem, not a state one.
          if (|(act_v & bsel))           st_err = 1'b1;
          else if (!(|(rp_zero_v & bsel))) tm_err = 1'b1;
        end
        E_RD, E_WR: begin
          rsp_d.code = (rcw == E_RD) ? C_RD : C_WR;
          rsp_d.col  = addr_i[9:0];
          rsp_d.ap   = addr_i[10];
          if (addr_i[10]) pre_want = bsel;
          if (!(|(act_v & bsel)))         st_err = 1'b1;
          else if (!(|(rcd_ok_v & bsel))) tm_err = 1'b1;
        end
        E_PRE: begin
          if (addr_i[10]) begin
            rsp_d.code = C_PREA;
            pre_want   = act_v;
          end else begin
            rsp_d.code = C_PRE;
            pre_want   = act_v & bsel;
          end
          // Idle/precharging targets are silently skipped.
          if (|(pre_want & ~ras_ok_v)) tm_err = 1'b1;
        end
        E_REF, E_MRS: begin
          rsp_d.code = (rcw == E_REF) ? C_REF : C_MRS;
          if (rcw == E_MRS) rsp_d.row = addr_i;
          ref_want = (rcw == E_REF);
          if (|act_v)               st_err = 1'b1;
          else if (~&rp_zero_v)     tm_err = 1'b1;
        end
        default: ill = 1'b1;  // E_ILL
      endcase
      if (rfc_q != 8'd0) tm_err = 1'b1;
    end
    err_any  = st_err | tm_err | ill;
    rsp_d.ei = ill;
    rsp_d.es = st_err & ~ill;
    rsp_d.et = tm_err & ~st_err & ~ill;
  end

  // Errored commands are reported but leave bank and refresh state alone.
  assign act_go = err_any ? '0 : act_want;
  assign pre_go = err_any ? '0 : pre_want;

  always_comb begin
    rfc_d = (rfc_q != 8'd0) ? rfc_q - 8'd1 : 8'd0;
    if (ref_want && !err_any) rfc_d = RFC_LOAD;
    cnt_d = (err_any && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    ddr2_bank #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) u_bank (
      .gclk_unused_i (1'b0),
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .act_i         (act_go[i]),
      .pre_i         (pre_go[i]),
      .active_o      (act_v[i]),
      .rp_zero_o     (rp_zero_v[i]),
      .rcd_ok_o      (rcd_ok_v[i]),
      .ras_ok_o      (ras_ok_v[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_q <= '0;
      cnt_q <= 8'd0;
      rfc_q <= 8'd0;
    end else begin
      rsp_q <= rsp_d;
      cnt_q <= cnt_d;
      rfc_q <= rfc_d;
    end
  end

  assign cmd_valid_o   = rsp_q.valid;
  assign cmd_code_o    = rsp_q.code;
  assign cmd_ba_o      = rsp_q.ba;
  assign cmd_row_o     = rsp_q.row;
  assign cmd_col_o     = rsp_q.col;
  assign cmd_ap_o      = rsp_q.ap;
  assign err_state_o   = rsp_q.es;
  assign err_timing_o  = rsp_q.et;
  assign err_illegal_o = rsp_q.ei;
  assign err_cnt_o     = cnt_q;
  assign bank_open_o   = act_v;  // straight from the bank state flops

  logic unused_ok;
  assign unused_ok = cs_n_i[1];
endmodule

// File: tb/tb_ddr2_cmd_decoder.sv
// Scoreboard bench for ddr2_cmd_decoder: the driver pushes the reference
// model's expected outputs for every sampled edge; the monitor pops one entry
// per cycle and compares the full output set. The model works on absolute
// cycle numbers (time of last ACT, time a bank/refresh becomes ready).
module tb_ddr2_cmd_decoder;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 12, T_RFC = 43;
  localparam bit [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
  localparam bit [2:0] WR = 3'b100, RD = 3'b101, ILL = 3'b110, NOP = 3'b111;

  logic        clk = 1'b0, rst_n = 1'b0, cke = 1'b0;
  logic [1:0]  cs_n = 2'b11, ba = 2'd0;
  logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [14:0] addr = '0;
  logic        cmd_valid, cmd_ap, err_state, err_timing, err_illegal;
  logic [2:0]  cmd_code;
  logic [1:0]  cmd_ba;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [3:0]  bank_open;
  logic [7:0]  err_cnt;

  ddr2_cmd_decoder #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .cs_n_i(cs_n),
    .ras_n_i(ras_n), .cas_n_i(cas_n), .we_n_i(we_n), .ba_i(ba), .addr_i(addr),
    .cmd_valid_o(cmd_valid), .cmd_code_o(cmd_code), .cmd_ba_o(cmd_ba),
    .cmd_row_o(cmd_row), .cmd_col_o(cmd_col), .cmd_ap_o(cmd_ap),
    .bank_open_o(bank_open), .err_state_o(err_state), .err_timing_o(err_timing),
    .err_illegal_o(err_illegal), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [2:0]  code;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [9:0]  col;
    logic        ap;
    logic [3:0]  open;
    logic        es, et, ei;
    logic [7:0]  cnt;
  } obs_t;

  obs_t expq[$];
  int   errors = 0, checks = 0;

  // reference state
  bit mopen[4];
  int act_t[4], pre_rdy[4];
  int ref_rdy = 0, ecnt = 0, now = 0;

  function automatic string fmt(obs_t o);
    return $sformatf("v=%0d code=%0d ba=%0d row=%h col=%h ap=%0d open=%b es=%0d et=%0d ei=%0d cnt=%0d",
                     o.v, o.code, o.ba, o.row, o.col, o.ap, o.open, o.es, o.et, o.ei, o.cnt);
  endfunction

  function automatic void model_reset();
    now++;
    for (int i = 0; i < 4; i++) begin mopen[i] = 0; pre_rdy[i] = 0; end
    ref_rdy = 0;
    ecnt    = 0;
  endfunction

  function automatic obs_t model(bit c_ke, bit [1:0] cs, bit [2:0] rcw, bit [1:0] b, bit [14:0] a);
    obs_t e;
    bit st, tm, il, anyopen, anyprech;
    e = '0; st = 0; tm = 0; il = 0; anyopen = 0; anyprech = 0;
    now++;
    for (int i = 0; i < 4; i++) begin
      anyopen |= mopen[i];
      if (now < pre_rdy[i]) anyprech = 1;
    end
    if (c_ke && !cs[0] && rcw != NOP) begin
      e.v  = 1;
      e.ba = b;
      case (rcw)
        ACT: begin
          e.code = 3'd1; e.row = a;
          if (mopen[b]) st = 1; else if (now < pre_rdy[b]) tm = 1;
        end
        RD, WR: begin
          e.code = (rcw == RD) ? 3'd2 : 3'd3; e.col = a[9:0]; e.ap = a[10];
          if (!mopen[b]) st = 1; else if (now - act_t[b] < T_RCD) tm = 1;
        end
        PRE: begin
          e.code = a[10] ? 3'd5 : 3'd4;
          for (int i = 0; i < 4; i++)
            if (mopen[i] && (a[10] || i == int'(b)) && now - act_t[i] < T_RAS) tm = 1;
        end
        REF, MRS: begin
          e.code = (rcw == REF) ? 3'd6 : 3'd7;
          if (rcw == MRS) e.row = a;
          if (anyopen) st = 1; else if (anyprech) tm = 1;
        end
        default: il = 1;
      endcase
      if (now < ref_rdy) tm = 1;
      e.ei = il; e.es = !il && st; e.et = !il && !st && tm;
      if (il || st || tm) begin
        if (ecnt < 255) ecnt++;
      end else begin
        case (rcw)
          ACT: begin mopen[b] = 1; act_t[b] = now; end
          RD, WR: if (a[10]) begin mopen[b] = 0; pre_rdy[b] = now + T_RP; end
          PRE:
            for (int i = 0; i < 4; i++)
              if (mopen[i] && (a[10] || i == int'(b))) begin mopen[i] = 0; pre_rdy[i] = now + T_RP; end
          REF: ref_rdy = now + T_RFC;
          default: ;
        endcase
      end
    end
    for (int i = 0; i < 4; i++) e.open[i] = mopen[i];
    e.cnt = 8'(ecnt);
    return e;
  endfunction

  task automatic step(input bit c_ke, input bit [1:0] cs, input bit [2:0] rcw,
                      input bit [1:0] b, input bit [14:0] a);
    @(negedge clk);
    rst_n = 1'b1; cke = c_ke; cs_n = cs; {ras_n, cas_n, we_n} = rcw; ba = b; addr = a;
    expq.push_back(model(c_ke, cs, rcw, b, a));
  endtask

  task automatic cmd(input bit [2:0] rcw, input bit [1:0] b, input bit [14:0] a);
    step(1'b1, 2'b10, rcw, b, a);
  endtask

  task automatic nop(input int n);
    repeat (n) step(1'b1, 2'b11, NOP, 2'd0, 15'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n = 1'b0; cke = 1'b0; cs_n = 2'b11; {ras_n, cas_n, we_n} = NOP;
      model_reset();
      expq.push_back('0);
      #1;
      checks++;
      if (bank_open !== 4'd0 || err_cnt !== 8'd0 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL async_reset: got open=%b cnt=%0d v=%0d, want all 0", bank_open, err_cnt, cmd_valid);
      end
    end
  endtask

  // monitor
  initial begin
    obs_t exp_o, got;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        exp_o = expq.pop_front();
        got = {cmd_valid, cmd_code, cmd_ba, cmd_row, cmd_col, cmd_ap, bank_open,
               err_state, err_timing, err_illegal, err_cnt};
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL out@%0t: got %s | want %s", $time, fmt(got), fmt(exp_o));
        end
      end
    end
  end

  // driver
  initial begin
    int unsigned r;
    bit [2:0]    rcw;
    bit [14:0]   a;
    bit [1:0]    cs;
    bit          ck;

    reset_cycles(3);

    // ACT then RD exactly tRCD later
    cmd(ACT, 2'd1, 15'h1234); nop(3); cmd(RD, 2'd1, 15'h0008);
    // WR two cycles after ACT: too early
    cmd(ACT, 2'd0, 15'h0042); nop(1); cmd(WR, 2'd0, 15'h0010);
    // RD to idle bank
    cmd(RD, 2'd2, 15'h0003);
    nop(2);
    reset_cycles(1);

    // PREA after tRAS, then ACT at +3 (early) and +4 (legal)
    cmd(ACT, 2'd0, 15'h0100); cmd(ACT, 2'd3, 15'h0300); nop(11);
    cmd(PRE, 2'd2, 15'h0400);
    nop(2); cmd(ACT, 2'd0, 15'h0001); cmd(ACT, 2'd0, 15'h0002);
    // PRE too early, then at tRAS; then REF and ACT inside/after tRFC
    cmd(PRE, 2'd0, 15'h0000); nop(10); cmd(PRE, 2'd0, 15'h0000);
    nop(3); cmd(REF, 2'd0, 15'h0000);
    nop(9); cmd(ACT, 2'd1, 15'h0005);
    nop(32); cmd(ACT, 2'd1, 15'h0006);
    // power-down and deselect hide commands
    step(1'b0, 2'b10, ACT, 2'd2, 15'h0777);
    step(1'b1, 2'b01, ACT, 2'd2, 15'h0777);
    // MRS with a bank open -> state error
    cmd(MRS, 2'd0, 15'h0abc);

    // saturate the error counter, then reset mid-sequence
    repeat (300) cmd(ILL, 2'(r), 15'h5555);
    reset_cycles(2);
    cmd(RD, 2'd1, 15'h0001);   // bank 1 was open before reset
    cmd(MRS, 2'd0, 15'h0abc);  // all idle now: legal

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      a = 15'($urandom);
      if      (r < 45) rcw = NOP;
      else if (r < 65) rcw = ACT;
      else if (r < 73) rcw = RD;
      else if (r < 81) rcw = WR;
      else if (r < 89) begin rcw = PRE; a[10] = ($urandom_range(0, 5) == 0); end
      else if (r < 90) rcw = REF;
      else if (r < 91) rcw = MRS;
      else if (r < 94) rcw = ILL;
      else             rcw = NOP;
      ck = ($urandom_range(0, 15) != 0);
      cs = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0)};
      step(ck, cs, rcw, 2'($urandom_range(0, 3)), a);
    end
    nop(2);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr2_cmd_decoder.md
DDR2_CMD_DECODER -- requirements
Module: ddr2_cmd_decoder

Interface
REQ-001 SHALL have parameter T_RCD, default 4, meaning the minimum cycles from ACT to RD/WR on the same bank.
REQ-002 SHALL have parameter T_RP, default 4, meaning the minimum cycles from PRE or auto-precharge to ACT on the same bank.
REQ-003 SHALL have parameter T_RAS, default 12, meaning the minimum cycles from ACT to PRE on the same bank.
REQ-004 SHALL have parameter T_RFC, default 43, meaning the minimum cycles from REF to any non-NOP command; all T_* values are 1..255.
REQ-005 clk  input  1  command clock; the CA bus is sampled on the rising edge (the bus is already half-cycle aligned by the PHY).
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cke  input  1  clock enable; low means power-down and all commands are ignored.
REQ-008 cs_n  input  2  chip selects; only rank 0 (cs_n[0]) is decoded.
REQ-009 ras_n, cas_n, we_n  input  1 each  command strobes.
REQ-010 ba  input  2  bank address.
REQ-011 addr  input  15  row / column / mode-register address.
REQ-012 cmd_valid  output  1  one-cycle pulse marking a decoded non-NOP command.
REQ-013 cmd_code  output  3  decoded command: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS.
REQ-014 cmd_ba  output  2, cmd_row  output  15, cmd_col  output  10, cmd_ap  output  1  fields of the decoded command.
REQ-015 bank_open  output  4  per-bank row-open status, one bit per bank.
REQ-016 err_state, err_timing, err_illegal  output  1 each  one-cycle error pulses.
REQ-017 err_cnt  output  8  saturating count of errored commands.

Function
REQ-018 SHALL decode only when cke=1 and cs_n[0]=0. Otherwise the cycle is a NOP (cmd_valid=0).
REQ-019 SHALL decode {ras_n,cas_n,we_n} as follows: 011 ACT; 101 RD; 100 WR; 010 PRE (PREA if addr[10]=1); 001 REF; 000 MRS; 111 NOP; 110 illegal.
REQ-020 SHALL register all outputs one cycle after the sampling edge; latency is exactly 1 cycle.
REQ-021 Field mapping: cmd_row=addr for ACT; cmd_col=addr[9:0] and cmd_ap=addr[10] for RD/WR; cmd_row=addr for MRS; cmd_ba=ba always; all unused fields are 0.
REQ-022 Each of the 4 banks SHALL have an FSM with states IDLE, ACTIVE and PRECHARGING, plus an 8-bit tRCD/tRAS counter and an 8-bit tRP counter.
REQ-023 ACT to an IDLE bank with tRP expired -> ACTIVE; this loads tRCD=T_RCD and tRAS=T_RAS, which count down to 0 each cycle.
REQ-024 PRE to an ACTIVE bank with tRAS=0 -> PRECHARGING, loading tRP=T_RP; tRP reaching 0 returns the bank to IDLE.
REQ-025 PRE to an IDLE or PRECHARGING bank SHALL be a legal no-op. PREA SHALL apply REQ-024 to every ACTIVE bank; if any ACTIVE bank has tRAS≠0, the whole PREA is a timing error.
REQ-026 RD/WR SHALL be legal only when the bank is ACTIVE and tRCD=0. With cmd_ap=1 the bank goes to PRECHARGING with tRP=T_RP in the same cycle.
REQ-027 REF and MRS SHALL be legal only when all banks are IDLE and the global tRFC counter is 0. REF loads tRFC=T_RFC.
REQ-028 Any non-NOP command while tRFC≠0 SHALL raise err_timing.
REQ-029 Wrong bank state raises err_state; a counter not expired raises err_timing; the 110 encoding raises err_illegal. err_state takes priority over err_timing; at most one flag pulses per command.
REQ-030 An errored command SHALL still be reported (cmd_valid=1 with its code) but SHALL NOT change bank or refresh state.
REQ-031 err_cnt SHALL increment by 1 per errored command and saturate at 255.
REQ-032 Counters SHALL keep decrementing while cke=0 and SHALL never wrap below 0.
REQ-033 bank_open[i]=1 exactly while bank i is ACTIVE, and it is registered with the other outputs.

Reset
REQ-034 When rst_n=0, all outputs SHALL be 0, all banks IDLE, and all counters 0, asynchronously.
REQ-035 Reset asserted mid-operation SHALL discard all bank state; the first command after release is judged against the all-IDLE state.

Verification
REQ-036 ACT ba=1 row=0x1234 at cycle n, then RD ba=1 col=0x08 at n+4 -> cmd_valid, cmd_code=2, cmd_col=0x008, no error, bank_open=4'b0010.
REQ-037 ACT ba=0 at cycle n, then WR ba=0 at n+2 -> err_timing=1, err_cnt=1, and the bank stays ACTIVE.
REQ-038 RD to IDLE bank 2 -> err_state=1, cmd_code=2; the bank state is unchanged.
REQ-039 ACT on banks 0 and 3, PREA after 12 cycles -> bank_open=0; ACT bank 0 at +3 gives err_timing, and ACT bank 0 at +4 is legal.
REQ-040 REF with all banks IDLE, then ACT at +10 -> err_timing; ACT at +43 is legal. cke=0 with ACT strobes -> no cmd_valid.
REQ-041 Apply 300 illegal 110 commands -> err_cnt saturates at 255. Asserting rst_n mid-sequence clears err_cnt and bank_open immediately.
